// File: rtl/satisfaction_scan_controller_if.sv
// Handshake and detector bundle between a scan master, the scan
// controller and the shared satisfaction detector.
interface satisfaction_scan_controller_if;
    logic        start;
    logic        abort;
    logic [31:0] expected_table;
    logic [4:0]  det_vec;
    logic        det_result;
    logic        busy;
    logic        done;
    logic [31:0] truth_table;
    logic [5:0]  ones_count;
    logic        mismatch;

    modport master (
        output start, abort, expected_table, det_result,
        input  det_vec, busy, done, truth_table, ones_count, mismatch
    );

    modport slave (
        input  start, abort, expected_table, det_result,
        output det_vec, busy, done, truth_table, ones_count, mismatch
    );
endinterface

// File: rtl/satisfaction_scan_controller.sv
// Steps a combinational satisfaction detector through all 32 input
// vectors, builds its truth table and compares it with a golden one.
module satisfaction_scan_controller #(
    parameter int SETTLE_CYCLES = 2
) (
    input logic clk,
    input logic rst_n,
    satisfaction_scan_controller_if.slave bus
);
    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FINISH
    } state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  vec_q;
    logic [31:0] truth_q;
    logic [31:0] exp_q;
    logic [5:0]  ones_q;
    logic        busy_q;
    logic        done_q;
    logic        mis_q;

    logic        last_hold;
    logic [31:0] truth_d;
    logic [5:0]  ones_d;

    assign last_hold = (cnt_q == SETTLE);

    // Table and count as they become after sampling the current vector
    always_comb begin
        truth_d         = truth_q;
        truth_d[vec_q]  = bus.det_result;
        ones_d          = ones_q + {5'd0, bus.det_result};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            truth_q <= '0;
            exp_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b1;
                        truth_q <= '0;
                        ones_q  <= '0;
                        mis_q   <= 1'b0;
                        exp_q   <= bus.expected_table;
                        vec_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                HOLD: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        vec_q   <= '0;
                        cnt_q   <= '0;
                    end else if (last_hold) begin
                        truth_q <= truth_d;
                        ones_q  <= ones_d;
                        cnt_q   <= '0;
                        if (vec_q == 5'd31) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            mis_q   <= (truth_d != exp_q);
                            vec_q   <= '0;
                        end else begin
                            vec_q <= vec_q + 5'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.det_vec     = vec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.truth_table = truth_q;
    assign bus.ones_count  = ones_q;
    assign bus.mismatch    = mis_q;
endmodule

// File: tb/tb_satisfaction_scan_controller.sv
// Directed and randomized scans of two controllers (settle 2 and 0)
// against a truth-table level model of the detector and the scan.
module tb_satisfaction_scan_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v;
    logic        abort_v;
    logic        sel0;
    logic [31:0] exp_v;
    logic [31:0] tbl;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    satisfaction_scan_controller_if bus2 ();
    satisfaction_scan_controller_if bus0 ();

    assign bus2.start          = !sel0 && start_v;
    assign bus2.abort          = !sel0 && abort_v;
    assign bus2.expected_table = exp_v;
    assign bus2.det_result     = tbl[bus2.det_vec];
    assign bus0.start          = sel0 && start_v;
    assign bus0.abort          = sel0 && abort_v;
    assign bus0.expected_table = exp_v;
    assign bus0.det_result     = tbl[bus0.det_vec];

    satisfaction_scan_controller #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    satisfaction_scan_controller #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    logic        o_busy, o_done, o_mis;
    logic [4:0]  o_vec;
    logic [31:0] o_truth;
    logic [5:0]  o_ones;

    assign o_busy  = sel0 ? bus0.busy : bus2.busy;
    assign o_done  = sel0 ? bus0.done : bus2.done;
    assign o_mis   = sel0 ? bus0.mismatch : bus2.mismatch;
    assign o_vec   = sel0 ? bus0.det_vec : bus2.det_vec;
    assign o_truth = sel0 ? bus0.truth_table : bus2.truth_table;
    assign o_ones  = sel0 ? bus0.ones_count : bus2.ones_count;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference detector: trying wins, else dying kills it, else any asset
    function automatic logic [31:0] ref_table();
        logic [31:0] t;
        logic [4:0]  v;
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            if (v[0])      t[i] = 1'b1;
            else if (v[1]) t[i] = 1'b0;
            else           t[i] = v[4] | v[3] | v[2];
        end
        return t;
    endfunction

    // Starts a scan, tracks det_vec against the per-vector dwell and
    // returns the start-to-done latency; ends on the done cycle.
    task automatic run_scan(input int s, input bit hold,
                            output logic [31:0] exp_cap, output int lat);
        bit vec_ok;
        int k;
        @(negedge clk);
        start_v = 1'b1;
        exp_cap = exp_v;
        @(negedge clk);
        chk("start_busy", 64'(o_busy), 64'(1));
        chk("start_vec", 64'(o_vec), 64'(0));
        if (!hold) start_v = 1'b0;
        exp_v  = $urandom;
        vec_ok = 1'b1;
        k      = 0;
        while (!o_done && k < 5000) begin
            if (o_vec !== 5'(k / (s + 1))) vec_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        lat = k;
        chk("vec_dwell", 64'(vec_ok), 64'(1));
        chk("latency", 64'(lat), 64'(32 * (s + 1)));
    endtask

    task automatic check_results(input string tag, input logic [31:0] ecap);
        chk({tag, "_truth"}, 64'(o_truth), 64'(tbl));
        chk({tag, "_ones"}, 64'(o_ones), 64'($countones(tbl)));
        chk({tag, "_mis"}, 64'(o_mis), 64'(tbl != ecap));
        chk({tag, "_busy"}, 64'(o_busy), 64'(0));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(o_done), 64'(0));
        repeat (3) @(negedge clk);
        chk({tag, "_hold"}, 64'(o_truth), 64'(tbl));
    endtask

    logic [31:0] ecap;
    int          lat;
    bit          seen_done;

    initial begin
        rst_n   = 1'b0;
        start_v = 1'b0;
        abort_v = 1'b0;
        sel0    = 1'b0;
        exp_v   = 32'hBBBB_BBBA;
        tbl     = ref_table();
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus2.busy), 64'(0));
        chk("rst_done", 64'(bus2.done), 64'(0));
        chk("rst_vec", 64'(bus2.det_vec), 64'(0));
        chk("rst_truth", 64'(bus2.truth_table), 64'(0));
        chk("rst_ones", 64'(bus2.ones_count), 64'(0));
        chk("rst_mis", 64'(bus2.mismatch), 64'(0));
        chk("rst_busy0", 64'(bus0.busy), 64'(0));
        rst_n = 1'b1;
        chk("ref_tbl", 64'(tbl), 64'(32'hBBBB_BBBA));

        run_scan(2, 1'b0, ecap, lat);
        check_results("ref", ecap);
        chk("ref_ones23", 64'(o_ones), 64'(23));

        tbl = ref_table() & ~32'h80;
        exp_v = 32'hBBBB_BBBA;
        run_scan(2, 1'b0, ecap, lat);
        check_results("fault", ecap);
        chk("fault_tbl", 64'(o_truth), 64'(32'hBBBB_BB3A));
        chk("fault_mis1", 64'(o_mis), 64'(1));

        for (int r = 0; r < 4; r++) begin
            tbl   = $urandom;
            exp_v = ($urandom_range(0, 1) == 1) ? tbl : $urandom;
            run_scan(2, 1'b0, ecap, lat);
            check_results("rand", ecap);
        end

        tbl = ref_table();
        @(negedge clk);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        repeat (9) @(negedge clk);
        abort_v = 1'b1;
        @(negedge clk);
        abort_v = 1'b0;
        chk("abort_busy", 64'(o_busy), 64'(0));
        chk("abort_vec", 64'(o_vec), 64'(0));
        chk("abort_truth", 64'(o_truth), 64'(32'h2));
        chk("abort_ones", 64'(o_ones), 64'(1));
        chk("abort_mis", 64'(o_mis), 64'(0));
        seen_done = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (o_done || o_busy) seen_done = 1'b1;
        end
        chk("abort_idle", 64'(seen_done), 64'(0));

        start_v = 1'b1;
        abort_v = 1'b1;
        @(negedge clk);
        chk("sa_busy", 64'(o_busy), 64'(0));
        start_v = 1'b0;
        abort_v = 1'b0;
        repeat (3) @(negedge clk);
        chk("sa_idle", 64'(o_busy), 64'(0));

        tbl = $urandom;
        run_scan(2, 1'b1, ecap, lat);
        chk("held_truth", 64'(o_truth), 64'(tbl));
        @(negedge clk);
        chk("held_gap", 64'(o_busy), 64'(0));
        @(negedge clk);
        chk("held_rescan", 64'(o_busy), 64'(1));
        chk("held_clear", 64'(o_truth), 64'(0));
        start_v = 1'b0;
        abort_v = 1'b1;
        @(negedge clk);
        abort_v = 1'b0;
        chk("held_abort", 64'(o_busy), 64'(0));

        tbl = ref_table();
        @(negedge clk);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        repeat (40) @(negedge clk);
        chk("pre_rst_nz", 64'(o_truth != 0), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(o_busy), 64'(0));
        chk("mrst_vec", 64'(o_vec), 64'(0));
        chk("mrst_truth", 64'(o_truth), 64'(0));
        chk("mrst_ones", 64'(o_ones), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (o_done || o_busy) seen_done = 1'b1;
        end
        chk("mrst_idle", 64'(seen_done), 64'(0));

        sel0 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tbl   = (r == 0) ? ref_table() : $urandom;
            exp_v = (r == 0) ? 32'hBBBB_BBBA : $urandom;
            run_scan(0, 1'b0, ecap, lat);
            check_results("s0", ecap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
